// File: rtl/stf_sync_detect.sv
// Short-training-field detector for the RX sample stream.
// Lag-16 delay-and-correlate metric over a 16-sample window; a plateau of
// MIN_PLATEAU consecutive qualifying samples produces one short_detected
// pulse, followed by HOLDOFF ignored metric samples before re-arming.
// Optional build macro STF_CFO_OUT_EN adds cfo_re/cfo_im, the window
// correlation sums captured at each detection.
module stf_sync_detect #(
  parameter int unsigned MIN_PLATEAU = 48,
  parameter int unsigned HOLDOFF     = 160
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear,
  input  logic [31:0]        sample_in,
  input  logic               sample_in_strobe,
  input  logic [3:0]         threshold,
  input  logic [35:0]        power_min,
`ifdef STF_CFO_OUT_EN
  output logic signed [36:0] cfo_re,
  output logic signed [36:0] cfo_im,
`endif
  output logic               short_detected,
  output logic               metric_strobe,
  output logic [7:0]         plateau_cnt
);

  typedef enum logic [1:0] {IDLE, PLATEAU, HOLD} state_t;

  // S1: delay line, fill tracking and per-sample products
  logic [31:0]        dly [16];
  logic [5:0]         fill;
  logic               s1_v, s1_full;
  logic signed [32:0] s1_re, s1_im;
  logic [31:0]        s1_pwr;

  logic signed [15:0] cur_i, cur_q, del_i, del_q;
  logic signed [32:0] prod_re_c, prod_im_c;
  logic [31:0]        prod_pwr_c;

  assign cur_i = sample_in[31:16];
  assign cur_q = sample_in[15:0];
  assign del_i = dly[15][31:16];
  assign del_q = dly[15][15:0];

  // s[n] * conj(s[n-16]) and |s[n]|^2; power wraps modulo 2^32, which is exact
  // because the true value never exceeds 2^31
  assign prod_re_c  = 33'(cur_i) * 33'(del_i) + 33'(cur_q) * 33'(del_q);
  assign prod_im_c  = 33'(cur_q) * 33'(del_i) - 33'(cur_i) * 33'(del_q);
  assign prod_pwr_c = 32'(cur_i) * 32'(cur_i) + 32'(cur_q) * 32'(cur_q);

  // S1 register stage: shift the delay line and capture products per strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < 16; i++) dly[i] <= '0;
      fill    <= '0;
      s1_v    <= 1'b0;
      s1_full <= 1'b0;
      s1_re   <= '0;
      s1_im   <= '0;
      s1_pwr  <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < 16; i++) dly[i] <= '0;
      fill    <= '0;
      s1_v    <= 1'b0;
      s1_full <= 1'b0;
      s1_re   <= '0;
      s1_im   <= '0;
      s1_pwr  <= '0;
    end else begin
      s1_v <= sample_in_strobe;
      if (sample_in_strobe) begin
        dly[0] <= sample_in;
        for (int unsigned i = 1; i < 16; i++) dly[i] <= dly[i-1];
        s1_re   <= prod_re_c;
        s1_im   <= prod_im_c;
        s1_pwr  <= prod_pwr_c;
        // the fill flag travels with its own sample so later strobes cannot skew it
        s1_full <= (fill >= 6'd31);
        if (fill != 6'd32) fill <= fill + 6'd1;
      end
    end
  end

  // S2: 16-deep product history and running window sums
  logic signed [32:0] hist_re  [16];
  logic signed [32:0] hist_im  [16];
  logic [31:0]        hist_pwr [16];
  logic signed [36:0] sum_re, sum_im;
  logic [35:0]        sum_pwr;
  logic               s2_v, s2_full;

  // S2 register stage: add the newest product, retire the one 16 back
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < 16; i++) begin
        hist_re[i] <= '0; hist_im[i] <= '0; hist_pwr[i] <= '0;
      end
      sum_re  <= '0;
      sum_im  <= '0;
      sum_pwr <= '0;
      s2_v    <= 1'b0;
      s2_full <= 1'b0;
    end else if (clear) begin
      for (int unsigned i = 0; i < 16; i++) begin
        hist_re[i] <= '0; hist_im[i] <= '0; hist_pwr[i] <= '0;
      end
      sum_re  <= '0;
      sum_im  <= '0;
      sum_pwr <= '0;
      s2_v    <= 1'b0;
      s2_full <= 1'b0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        sum_re  <= sum_re + 37'(s1_re) - 37'(hist_re[15]);
        sum_im  <= sum_im + 37'(s1_im) - 37'(hist_im[15]);
        sum_pwr <= sum_pwr + 36'(s1_pwr) - 36'(hist_pwr[15]);
        hist_re[0]  <= s1_re;
        hist_im[0]  <= s1_im;
        hist_pwr[0] <= s1_pwr;
        for (int unsigned i = 1; i < 16; i++) begin
          hist_re[i]  <= hist_re[i-1];
          hist_im[i]  <= hist_im[i-1];
          hist_pwr[i] <= hist_pwr[i-1];
        end
        s2_full <= s1_full;
      end
    end
  end

  // S3: ratio test (M/P > threshold/16) done as a cross-multiplied compare
  logic [36:0] abs_re, abs_im;
  logic [37:0] metric;
  logic [41:0] lhs, rhs;
  logic        qualify;

  assign abs_re  = sum_re[36] ? 37'(-sum_re) : 37'(sum_re);
  assign abs_im  = sum_im[36] ? 37'(-sum_im) : 37'(sum_im);
  assign metric  = 38'(abs_re) + 38'(abs_im);
  assign lhs     = {metric, 4'b0000};
  assign rhs     = 42'(threshold) * 42'(sum_pwr);
  assign qualify = s2_full && (lhs > rhs) && (sum_pwr >= power_min);

  logic [9:0] hold_cnt;
  state_t     state;

  // Plateau FSM with registered outputs, stepped by each metric decision
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      plateau_cnt    <= '0;
      hold_cnt       <= '0;
      metric_strobe  <= 1'b0;
      short_detected <= 1'b0;
`ifdef STF_CFO_OUT_EN
      cfo_re         <= '0;
      cfo_im         <= '0;
`endif
    end else if (clear) begin
      state          <= IDLE;
      plateau_cnt    <= '0;
      hold_cnt       <= '0;
      metric_strobe  <= 1'b0;
      short_detected <= 1'b0;
`ifdef STF_CFO_OUT_EN
      cfo_re         <= '0;
      cfo_im         <= '0;
`endif
    end else begin
      metric_strobe  <= s2_v;
      short_detected <= 1'b0;
      case (state)
        IDLE: begin
          if (s2_v && qualify) begin
            state       <= PLATEAU;
            plateau_cnt <= 8'd1;
          end
        end
        PLATEAU: begin
          if (s2_v) begin
            if (!qualify) begin
              state       <= IDLE;
              plateau_cnt <= '0;
            end else begin
              plateau_cnt <= plateau_cnt + 8'd1;
              if (plateau_cnt + 8'd1 == 8'(MIN_PLATEAU)) begin
                short_detected <= 1'b1;
                state          <= HOLD;
                hold_cnt       <= '0;
`ifdef STF_CFO_OUT_EN
                cfo_re         <= sum_re;
                cfo_im         <= sum_im;
`endif
              end
            end
          end
        end
        HOLD: begin
          // the count shows MIN_PLATEAU only in the pulse cycle, then reads 0
          plateau_cnt <= '0;
          if (s2_v) begin
            if (hold_cnt + 10'd1 == 10'(HOLDOFF)) begin
              state    <= IDLE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 10'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stf_sync_detect.sv
// Bench for stf_sync_detect: directed STF / noise / clear scenarios against a
// sample-level model that recomputes each 16-sample window from the stored
// sample history. Build with STF_CFO_OUT_EN to also check cfo_re/cfo_im.
module tb_stf_sync_detect;

  localparam int unsigned MINP = 48;
  localparam int unsigned HOLD = 240;
  localparam int NEV = 8192;

  logic        clk = 1'b0;
  logic        rstn, clear, sample_in_strobe;
  logic [31:0] sample_in;
  logic [3:0]  threshold;
  logic [35:0] power_min;
  logic        short_detected, metric_strobe;
  logic [7:0]  plateau_cnt;
`ifdef STF_CFO_OUT_EN
  logic signed [36:0] cfo_re, cfo_im;
`endif

  always #5 clk = ~clk;

  stf_sync_detect #(.MIN_PLATEAU(MINP), .HOLDOFF(HOLD)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .clear            (clear),
    .sample_in        (sample_in),
    .sample_in_strobe (sample_in_strobe),
    .threshold        (threshold),
    .power_min        (power_min),
`ifdef STF_CFO_OUT_EN
    .cfo_re           (cfo_re),
    .cfo_im           (cfo_im),
`endif
    .short_detected   (short_detected),
    .metric_strobe    (metric_strobe),
    .plateau_cnt      (plateau_cnt)
  );

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  int nchk = 0, npass = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    nchk++;
    if (act == req) npass++;
    else $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, ecount, act, req);
  endtask

  // expected output events, indexed by the edge count after which they show
  bit     ev_v   [NEV];
  bit     ev_sd  [NEV];
  bit     ev_clr [NEV];
  int     ev_pc  [NEV];
  longint ev_cre [NEV];
  longint ev_cim [NEV];

  // sample-level model
  logic [31:0] hist[$];
  int samp_edge [1024];
  int m_run = 0, m_hold_left = 0, m_first_q = -1, m_pulse_idx = -1, m_pulses = 0;

  task automatic model_clear();
    hist.delete();
    m_run = 0; m_hold_left = 0; m_first_q = -1; m_pulse_idx = -1; m_pulses = 0;
  endtask

  task automatic model_step(input logic [31:0] s, input int e);
    int n, pc;
    longint sre, sim, spw, ci, cq, di, dq, mag;
    logic [31:0] cur, del;
    bit q, sd;
    hist.push_back(s);
    n = hist.size() - 1;
    if (n < 1024) samp_edge[n] = e;
    sre = 0; sim = 0; spw = 0;
    for (int j = (n > 15 ? n - 15 : 0); j <= n; j++) begin
      cur = hist[j];
      del = (j >= 16) ? hist[j-16] : 32'd0;
      ci = longint'($signed(cur[31:16])); cq = longint'($signed(cur[15:0]));
      di = longint'($signed(del[31:16])); dq = longint'($signed(del[15:0]));
      sre += ci * di + cq * dq;
      sim += cq * di - ci * dq;
      spw += ci * ci + cq * cq;
    end
    mag = (sre < 0 ? -sre : sre) + (sim < 0 ? -sim : sim);
    q = (n >= 31) && (16 * mag > longint'(threshold) * spw) && (spw >= longint'(power_min));
    if (q && m_first_q < 0) m_first_q = n;
    sd = 1'b0;
    if (m_hold_left > 0) begin
      m_hold_left--; pc = 0;
    end else if (q) begin
      m_run++; pc = m_run;
      if (m_run == int'(MINP)) begin
        sd = 1'b1; m_run = 0; m_hold_left = int'(HOLD);
        m_pulse_idx = n; m_pulses++;
      end
    end else begin
      m_run = 0; pc = 0;
    end
    ev_v[e+2] = 1'b1; ev_sd[e+2] = sd; ev_pc[e+2] = pc;
    ev_cre[e+2] = sre; ev_cim[e+2] = sim;
  endtask

  // drive one cycle of inputs (called at posedge+1), update the model
  task automatic step(input bit stb, input logic [31:0] d, input bit clr);
    int e;
    e = ecount + 1;
    if (e + 2 >= NEV) begin
      $display("FAIL event_table cycle=%0d actual=overflow required=fit", ecount);
      $fatal(1, "event table exhausted");
    end
    sample_in_strobe = stb; sample_in = d; clear = clr;
    if (clr) begin
      model_clear();
      ev_clr[e] = 1'b1; ev_v[e] = 1'b0; ev_v[e+1] = 1'b0; ev_v[e+2] = 1'b0;
    end else if (stb) begin
      model_step(d, e);
    end
    @(posedge clk); #1;
    sample_in_strobe = 1'b0; clear = 1'b0; sample_in = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0);
  endtask

  // per-cycle compare plus DUT-side monitors for the directed literal checks
  bit chk_en = 1'b0;
  int pc_hold = 0;
  longint cre_hold = 0, cim_hold = 0;
  int dut_pulses = 0, max_pc = 0, last_pulse_e = -1;
  bit e_ms, e_sd;
  int e_pc;

  always @(negedge clk) begin
    if (chk_en && ecount < NEV) begin
      if (ev_clr[ecount]) begin
        e_ms = 1'b0; e_sd = 1'b0; e_pc = 0; cre_hold = 0; cim_hold = 0;
      end else if (ev_v[ecount]) begin
        e_ms = 1'b1; e_sd = ev_sd[ecount]; e_pc = ev_pc[ecount];
        if (e_sd) begin cre_hold = ev_cre[ecount]; cim_hold = ev_cim[ecount]; end
      end else begin
        e_ms = 1'b0; e_sd = 1'b0; e_pc = pc_hold;
      end
      chk("metric_strobe", longint'(metric_strobe), longint'(e_ms));
      chk("short_detected", longint'(short_detected), longint'(e_sd));
      chk("plateau_cnt", longint'(plateau_cnt), longint'(e_pc));
`ifdef STF_CFO_OUT_EN
      chk("cfo_re", longint'(cfo_re), cre_hold);
      chk("cfo_im", longint'(cfo_im), cim_hold);
`endif
      pc_hold = e_sd ? 0 : e_pc;
      if (short_detected) begin dut_pulses++; last_pulse_e = ecount; end
      if (int'(plateau_cnt) > max_pc) max_pc = int'(plateau_cnt);
    end
  end

  function automatic logic [31:0] stf(input int k);
    int p;
    logic [15:0] i, q;
    p = k % 16;
    if (p == 6) begin i = 16'(8000); q = 16'(-6000); end
    else begin i = 16'(1000 + 100 * p); q = 16'(500 - 80 * p); end
    return {i, q};
  endfunction

  function automatic logic [31:0] neg(input logic [31:0] s);
    logic [15:0] i, q;
    i = 16'(-$signed(s[31:16]));
    q = 16'(-$signed(s[15:0]));
    return {i, q};
  endfunction

  task automatic begin_test();
    step(1'b0, $urandom, 1'b1);
    dut_pulses = 0; max_pc = 0; last_pulse_e = -1;
  endtask

  task automatic burst_pair(input int gap);
    begin_test();
    for (int k = 0; k < 160; k++) step(1'b1, stf(k), 1'b0);
    for (int k = 0; k < gap; k++) step(1'b1, 32'd0, 1'b0);
    for (int k = 0; k < 160; k++) step(1'b1, stf(k), 1'b0);
    idle(6);
  endtask

  logic [31:0] lfsr;

  initial begin
    rstn = 1'b1; clear = 1'b0; sample_in_strobe = 1'b0; sample_in = '0;
    threshold = 4'd12; power_min = 36'h100;
    #3 rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      sample_in = $urandom; sample_in_strobe = 1'($urandom_range(0, 1));
      clear = 1'($urandom_range(0, 1)); threshold = 4'($urandom);
      power_min = {4'($urandom), 32'($urandom)};
      #2;
      chk("rst_short_detected", longint'(short_detected), 0);
      chk("rst_metric_strobe", longint'(metric_strobe), 0);
      chk("rst_plateau_cnt", longint'(plateau_cnt), 0);
    end
    @(posedge clk); #1;
    rstn = 1'b1; clear = 1'b0; sample_in_strobe = 1'b0;
    threshold = 4'd12; power_min = 36'h100;
    chk_en = 1'b1;
    idle(5);
    chk("post_rst_plateau_cnt", longint'(plateau_cnt), 0);
    chk("post_rst_pulses", dut_pulses, 0);

    // clean periodic STF
    begin_test();
    for (int k = 0; k < 160; k++) step(1'b1, stf(k), 1'b0);
    idle(6);
    chk("clean_model_first_qualify", m_first_q, 31);
    chk("clean_model_pulse_idx", m_pulse_idx, 78);
    chk("clean_pulses", dut_pulses, 1);
    chk("clean_pulse_latency", last_pulse_e - samp_edge[78], 2);
    chk("clean_max_plateau", max_pc, 48);

    // all-zero input: power gate
    begin_test();
    for (int k = 0; k < 300; k++) step(1'b1, 32'd0, 1'b0);
    idle(6);
    chk("zero_pulses", dut_pulses, 0);
    chk("zero_max_plateau", max_pc, 0);

    // LFSR noise with occasional idle cycles between strobes
    begin_test();
    lfsr = 32'h1234_5678;
    for (int k = 0; k < 300; k++) begin
      if (k % 4 == 3) idle(1);
      step(1'b1, lfsr, 1'b0);
      lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'hB4BC_D35C : 32'd0);
    end
    idle(6);
    chk("noise_pulses", dut_pulses, 0);
    nchk++;
    if (max_pc <= 10) npass++;
    else $display("FAIL noise_max_plateau actual=%0d required<=10", max_pc);

    // plateau broken by one sign-inverted sample
    begin_test();
    for (int k = 0; k < 70; k++) step(1'b1, stf(k), 1'b0);
    step(1'b1, neg(stf(70)), 1'b0);
    for (int k = 71; k < 231; k++) step(1'b1, stf(k), 1'b0);
    idle(6);
    chk("broken_model_pulse_idx", m_pulse_idx, 149);
    chk("broken_pulses", dut_pulses, 1);
    chk("broken_pulse_latency", last_pulse_e - samp_edge[149], 2);

    // holdoff: short gap keeps the second burst inside holdoff
    burst_pair(20);
    chk("holdoff_short_model_pulses", m_pulses, 1);
    chk("holdoff_short_pulses", dut_pulses, 1);

    // holdoff: long gap re-arms before the second burst
    burst_pair(200);
    chk("holdoff_long_model_pulses", m_pulses, 2);
    chk("holdoff_long_pulses", dut_pulses, 2);

    // clear mid-plateau, with a strobe in the clear cycle that must be dropped
    begin_test();
    for (int k = 0; k <= 60; k++) step(1'b1, stf(k), 1'b0);
    idle(3);
    chk("clear_plateau_before", longint'(plateau_cnt), 30);
    dut_pulses = 0;
    step(1'b1, stf(61), 1'b1);
    for (int k = 61; k < 161; k++) step(1'b1, stf(k), 1'b0);
    idle(6);
    chk("clear_model_pulse_idx", m_pulse_idx, 78);
    chk("clear_pulses", dut_pulses, 1);
    chk("clear_pulse_latency", last_pulse_e - samp_edge[78], 2);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", ecount);
    $fatal(1, "watchdog expired");
  end

endmodule
